// File: rtl/lift_pkg.sv
// Shared types and helpers for the N-floor lift controller.
package lift_pkg;

    // Controller modes.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMove = 2'd1,
        StDoor = 2'd2
    } lift_state_e;

    // Bits needed to hold a value in 0..n-1, never less than one bit.
    function automatic int unsigned lift_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lift_sched.sv
// SCAN scheduler: from the latched requests, the current floor and the
// current direction, decide whether to open here, move, and which way.
module lift_sched
    import lift_pkg::*;
#(
    parameter int unsigned FLOORS = 4
) (
    input  logic [FLOORS-1:0]             pending_i,
    input  logic [lift_width(FLOORS)-1:0] floor_i,
    input  logic                          dir_up_i,
    output logic                          serve_o,
    output logic                          move_o,
    output logic                          up_o
);

    localparam int unsigned FloorW = lift_width(FLOORS);

    logic any_above;
    logic any_below;

    // Classify every pending floor as above or below the car.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (pending_i[i]) begin
                if (FloorW'(i) > floor_i) any_above = 1'b1;
                if (FloorW'(i) < floor_i) any_below = 1'b1;
            end
        end
    end

    // Keep going up while work lies ahead, reverse only when nothing is ahead.
    always_comb begin
        serve_o = pending_i[floor_i];
        move_o  = 1'b0;
        up_o    = dir_up_i;
        if (!serve_o) begin
            if (any_above && (dir_up_i || !any_below)) begin
                move_o = 1'b1;
                up_o   = 1'b1;
            end else if (any_below) begin
                move_o = 1'b1;
                up_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lift_ctrl_n.sv
// N-floor lift controller: request latch, SCAN direction, timed travel and
// timed door cycle. Define LIFT_DOOR_HOLD_EN to add the door_hold input.
module lift_ctrl_n
    import lift_pkg::*;
#(
    parameter int unsigned FLOORS      = 4,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FLOORS-1:0]             req,
`ifdef LIFT_DOOR_HOLD_EN
    input  logic                          door_hold,
`endif
    output logic [FLOORS-1:0]             at_floor,
    output logic [lift_width(FLOORS)-1:0] floor_idx,
    output logic [FLOORS-1:0]             pending,
    output logic                          moving,
    output logic                          dir_up,
    output logic                          door_open
);

    localparam int unsigned FloorW = lift_width(FLOORS);
    localparam int unsigned MoveW  = lift_width(MOVE_CYCLES);
    localparam int unsigned DoorW  = lift_width(DOOR_CYCLES);

    localparam logic [FloorW-1:0] FloorTop = FloorW'(FLOORS - 1);
    localparam logic [MoveW-1:0]  MoveLast = MoveW'(MOVE_CYCLES - 1);
    localparam logic [DoorW-1:0]  DoorLast = DoorW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] FloorOne = FLOORS'(1);

    lift_state_e       state_q, state_d;
    logic [FloorW-1:0] floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [MoveW-1:0]  move_cnt_q, move_cnt_d;
    logic [DoorW-1:0]  door_cnt_q, door_cnt_d;
    logic              dir_up_q, dir_up_d;
    logic              moving_q, door_open_q;

    logic [FloorW-1:0] step_floor;
    logic [FLOORS-1:0] req_eff;
    logic [FLOORS-1:0] clr;
    logic              hold;
    logic              sched_serve, sched_move, sched_up;

`ifdef LIFT_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    lift_sched #(
        .FLOORS (FLOORS)
    ) u_sched (
        .pending_i (pending_q),
        .floor_i   (floor_q),
        .dir_up_i  (dir_up_q),
        .serve_o   (sched_serve),
        .move_o    (sched_move),
        .up_o      (sched_up)
    );

    // Floor reached at the end of the current travel step; saturates at the ends.
    always_comb begin
        step_floor = floor_q;
        if (dir_up_q && (floor_q != FloorTop)) begin
            step_floor = floor_q + FloorW'(1);
        end else if (!dir_up_q && (floor_q != '0)) begin
            step_floor = floor_q - FloorW'(1);
        end
    end

    // Next-state logic for the FSM, counters and request latch.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        req_eff    = req;
        clr        = '0;

        unique case (state_q)
            StIdle: begin
                if (sched_serve) begin
                    state_d    = StDoor;
                    door_cnt_d = '0;
                    clr        = FloorOne << floor_q;
                end else if (sched_move) begin
                    state_d    = StMove;
                    move_cnt_d = '0;
                    dir_up_d   = sched_up;
                end
            end
            StMove: begin
                if (move_cnt_q == MoveLast) begin
                    move_cnt_d = '0;
                    floor_d    = step_floor;
                    if (pending_q[step_floor]) begin
                        state_d    = StDoor;
                        door_cnt_d = '0;
                        clr        = FloorOne << step_floor;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + MoveW'(1);
                end
            end
            StDoor: begin
                // A call for the floor we are standing at only keeps the door open.
                req_eff[floor_q] = 1'b0;
                if (req[floor_q] || hold) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DoorLast) begin
                    door_cnt_d = '0;
                    if (sched_serve) begin
                        clr = FloorOne << floor_q;
                    end else if (sched_move) begin
                        state_d    = StMove;
                        move_cnt_d = '0;
                        dir_up_d   = sched_up;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    door_cnt_d = door_cnt_q + DoorW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Serving a floor wins over a new request for it on the same edge.
        pending_d = (pending_q | req_eff) & ~clr;
    end

    // All state, including the registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            floor_q     <= '0;
            pending_q   <= '0;
            move_cnt_q  <= '0;
            door_cnt_q  <= '0;
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            move_cnt_q  <= move_cnt_d;
            door_cnt_q  <= door_cnt_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= (state_d == StMove);
            door_open_q <= (state_d == StDoor);
        end
    end

    assign at_floor  = FloorOne << floor_q;
    assign floor_idx = floor_q;
    assign pending   = pending_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;
    assign door_open = door_open_q;

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Bench for lift_ctrl_n (FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3). Directed
// scenarios with literal checks plus a cycle-by-cycle behavioural model.
// Define LIFT_DOOR_HOLD_EN to also exercise the door_hold input.
module tb_lift_ctrl_n;

    localparam int FLOORS      = 4;
    localparam int MOVE_CYCLES = 4;
    localparam int DOOR_CYCLES = 3;
    localparam int FW          = $clog2(FLOORS);

`ifdef LIFT_DOOR_HOLD_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    localparam int MIdle = 0;
    localparam int MMove = 1;
    localparam int MDoor = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [FLOORS-1:0] req = '0;
    logic              door_hold = 1'b0;
    logic [FLOORS-1:0] at_floor;
    logic [FW-1:0]     floor_idx;
    logic [FLOORS-1:0] pending;
    logic              moving;
    logic              dir_up;
    logic              door_open;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    lift_ctrl_n #(
        .FLOORS      (FLOORS),
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
`ifdef LIFT_DOOR_HOLD_EN
        .door_hold (door_hold),
`endif
        .at_floor  (at_floor),
        .floor_idx (floor_idx),
        .pending   (pending),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_mode  = MIdle;
    int                m_floor = 0;
    int                m_left  = 0;   // cycles remaining in current travel step / door
    bit                m_dir   = 1'b1;
    bit [FLOORS-1:0]   m_pend  = '0;
    bit [FLOORS-1:0]   m_in;
    bit [FLOORS-1:0]   m_served;

    // Choose what to do next from the requests still outstanding.
    task automatic m_decide();
        bit above = 1'b0;
        bit below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (m_pend[i] && i > m_floor) above = 1'b1;
            if (m_pend[i] && i < m_floor) below = 1'b1;
        end
        if (m_pend[m_floor]) begin
            m_mode = MDoor; m_left = DOOR_CYCLES; m_served[m_floor] = 1'b1;
        end else if (above && (m_dir || !below)) begin
            m_mode = MMove; m_left = MOVE_CYCLES; m_dir = 1'b1;
        end else if (below) begin
            m_mode = MMove; m_left = MOVE_CYCLES; m_dir = 1'b0;
        end else begin
            m_mode = MIdle;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_mode = MIdle; m_floor = 0; m_left = 0; m_dir = 1'b1; m_pend = '0;
        end else begin
            m_in     = req;
            m_served = '0;
            if (m_mode == MIdle) begin
                m_decide();
            end else if (m_mode == MMove) begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        m_mode = MDoor; m_left = DOOR_CYCLES; m_served[m_floor] = 1'b1;
                    end else begin
                        m_left = MOVE_CYCLES;
                    end
                end
            end else begin
                if (m_in[m_floor] || (HoldEn && door_hold)) begin
                    m_left = DOOR_CYCLES;
                end else begin
                    m_left--;
                    if (m_left == 0) m_decide();
                end
                m_in[m_floor] = 1'b0;
            end
            m_pend = (m_pend | m_in) & ~m_served;
        end
    end

    // Compare every output against the model, away from the active edge.
    initial forever begin
        logic [FLOORS-1:0] e_at;
        @(negedge clk);
        if (cmp_en) begin
            e_at = '0;
            e_at[m_floor] = 1'b1;
            chk("model at_floor", 32'(at_floor), 32'(e_at));
            chk("model floor_idx", 32'(floor_idx), 32'(m_floor));
            chk("model pending", 32'(pending), 32'(m_pend));
            chk("model moving", 32'(moving), 32'(m_mode == MMove));
            chk("model dir_up", 32'(dir_up), 32'(m_dir));
            chk("model door_open", 32'(door_open), 32'(m_mode == MDoor));
        end
    end

    // ---------------- stimulus ----------------
    // Present r for one edge; return 1 time unit after that edge.
    task automatic step(input logic [FLOORS-1:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [FLOORS-1:0] r;
        int                n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        chk("rst at_floor", 32'(at_floor), 32'h1);
        chk("rst floor_idx", 32'(floor_idx), 32'h0);
        chk("rst pending", 32'(pending), 32'h0);
        chk("rst moving", 32'(moving), 32'h0);
        chk("rst dir_up", 32'(dir_up), 32'h1);
        chk("rst door_open", 32'(door_open), 32'h0);

        // Single call to floor 2 from floor 0.
        step(4'b0100);
        chk("s2 pending latched", 32'(pending), 32'h4);
        chk("s2 not yet moving", 32'(moving), 32'h0);
        step('0);
        chk("s2 moving", 32'(moving), 32'h1);
        run(3);
        chk("s2 still floor0", 32'(floor_idx), 32'h0);
        step('0);
        chk("s2 floor1", 32'(at_floor), 32'h2);
        chk("s2 moving at 1", 32'(moving), 32'h1);
        run(4);
        chk("s2 floor2", 32'(at_floor), 32'h4);
        chk("s2 door open", 32'(door_open), 32'h1);
        chk("s2 moving off", 32'(moving), 32'h0);
        chk("s2 pending clear", 32'(pending), 32'h0);
        run(2);
        chk("s2 door 3rd cycle", 32'(door_open), 32'h1);
        step('0);
        chk("s2 door closed", 32'(door_open), 32'h0);
        chk("s2 idle", 32'(moving), 32'h0);

        // SCAN: serve 3 before reversing to 0.
        do_reset();
        step(4'b1000);
        run(9);
        chk("s3 floor2 moving", 32'(floor_idx), 32'h2);
        chk("s3 passing 2", 32'(moving), 32'h1);
        step(4'b0001);
        chk("s3 pending both", 32'(pending), 32'h9);
        run(3);
        chk("s3 stop at 3", 32'(floor_idx), 32'h3);
        chk("s3 door at 3", 32'(door_open), 32'h1);
        chk("s3 pending 0 only", 32'(pending), 32'h1);
        run(3);
        chk("s3 reversed", 32'(dir_up), 32'h0);
        chk("s3 moving down", 32'(moving), 32'h1);
        run(4);
        chk("s3 pass 2", 32'(floor_idx), 32'h2);
        chk("s3 no stop 2", 32'(door_open), 32'h0);
        run(4);
        chk("s3 pass 1", 32'(floor_idx), 32'h1);
        chk("s3 no stop 1", 32'(moving), 32'h1);
        run(4);
        chk("s3 floor0", 32'(at_floor), 32'h1);
        chk("s3 door at 0", 32'(door_open), 32'h1);
        chk("s3 all served", 32'(pending), 32'h0);
        run(3);
        chk("s3 door closed", 32'(door_open), 32'h0);

        // Same-floor call during the door restarts the door timer.
        do_reset();
        step(4'b0001);
        step('0);
        chk("s4 door cycle1", 32'(door_open), 32'h1);
        step('0);
        step(4'b0001);
        chk("s4 restart no pending", 32'(pending), 32'h0);
        run(2);
        chk("s4 door cycle5", 32'(door_open), 32'h1);
        step('0);
        chk("s4 door closed", 32'(door_open), 32'h0);

        // Asynchronous reset between floors 1 and 2.
        do_reset();
        step(4'b0100);
        run(6);
        chk("s5 pre floor1", 32'(floor_idx), 32'h1);
        reset = 1'b1;
        #1;
        chk("s5 rst floor_idx", 32'(floor_idx), 32'h0);
        chk("s5 rst moving", 32'(moving), 32'h0);
        chk("s5 rst pending", 32'(pending), 32'h0);
        chk("s5 rst at_floor", 32'(at_floor), 32'h1);
        @(negedge clk);
        reset = 1'b0;

`ifdef LIFT_DOOR_HOLD_EN
        // Door held for five cycles, then a full door period after release.
        step(4'b0001);
        step('0);
        door_hold = 1'b1;
        run(5);
        chk("s6 held open", 32'(door_open), 32'h1);
        door_hold = 1'b0;
        run(2);
        chk("s6 open after release", 32'(door_open), 32'h1);
        step('0);
        chk("s6 closed", 32'(door_open), 32'h0);
`endif

        // Mixed traffic, checked by the model only.
        vecs[0] = '{4'b1111, 1};
        vecs[1] = '{4'b0000, 12};
        vecs[2] = '{4'b0010, 1};
        vecs[3] = '{4'b0000, 6};
        vecs[4] = '{4'b1001, 1};
        vecs[5] = '{4'b0000, 9};
        vecs[6] = '{4'b0100, 1};
        vecs[7] = '{4'b0000, 40};
        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].r);
            run(vecs[i].n - 1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lift_ctrl_n.md
# lift_ctrl_n

Parametrised N-floor lift controller with latched hall/car requests, SCAN-style direction scheduling, a timed floor-to-floor travel model and a timed door cycle. It replaces the fixed three-floor lift FSM as the lift block in the controller design. It is driven by debounced single-cycle request pulses and drives floor indicators, motion/direction status and the door actuator.

## Interface
- FLOORS, default 4, number of floors (2..16); floor 0 is the ground floor.
- MOVE_CYCLES, default 4, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, default 3, clock cycles the door stays open per stop (>=1).
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- req  input  FLOORS  request pulses, bit i = floor i; multiple bits may be set in one cycle.
- door_hold  input  1  present only with LIFT_DOOR_HOLD_EN; holds the door open.
- at_floor  output  FLOORS  one-hot current floor; all-zero never occurs.
- floor_idx  output  $clog2(FLOORS)  binary current floor.
- pending  output  FLOORS  latched, not-yet-served requests.
- moving  output  1  high in MOVE state.
- dir_up  output  1  current/last travel direction, 1 = up.
- door_open  output  1  high in DOOR state.

## Operation
- Reset values: state IDLE, floor_idx 0, at_floor = 1 (bit 0), pending 0, moving 0, dir_up 1, door_open 0, all counters 0.
- Request latch: pending[i] <= pending[i] | req[i], except that clear wins on the cycle floor i is served.
- States: IDLE, MOVE, DOOR.
- IDLE: if pending[floor_idx] -> DOOR, clear that bit. Else, if any pending bit is above floor_idx and dir_up=1, or no pending bit is below -> dir_up=1, MOVE. If any pending bit is below -> dir_up=0, MOVE. Else stay.
- MOVE: the travel counter counts MOVE_CYCLES edges. On the last one, floor_idx moves +/-1. If pending[new floor] is set -> DOOR, clear bit. Else stay in MOVE toward the next pending floor in the same direction.
- DOOR: door counter counts DOOR_CYCLES edges. A req for the current floor during DOOR restarts the counter and does not set pending. At expiry, apply the IDLE decision directly; no idle cycle is inserted when work is pending.
- SCAN rule: keep dir_up while any pending floor lies ahead. Reverse only when none lie ahead and some lie behind.
- Boundaries: never step above FLOORS-1 or below 0. An out-of-range direction forces the reversal rule. Requests are never lost.
- Reset mid-travel or mid-door returns immediately to floor 0, IDLE, door closed, pending cleared.

## Timing
- req at edge k -> pending visible after edge k. The IDLE decision uses registered pending, so MOVE starts at edge k+1.
- One floor of travel = MOVE_CYCLES cycles with moving=1. floor_idx/at_floor update on the same edge that moving may fall.
- A stop holds door_open=1 for exactly DOOR_CYCLES cycles, more if restarted or held.
- All outputs are registered or decoded from registers; there is no combinational path from req.

## Configuration
- LIFT_DOOR_HOLD_EN defined: adds the door_hold port. While door_hold=1 in DOOR, the door counter reloads and the door stays open. Release lets the door run a full DOOR_CYCLES.
- Not defined: no door_hold port; door closes strictly by the counter and req-restart rule.

## Structure
- Shared package lift_pkg: state enum (IDLE/MOVE/DOOR) and the width function for floor_idx/counters.
- One sub-module, lift_sched: combinational next-direction/next-action logic from pending, floor_idx and dir_up. Top level holds the counters, pending register and FSM.

## Test plan
- FLOORS=4, MOVE=4, DOOR=3. After reset: at_floor=0001, IDLE, door_open=0, dir_up=1.
- req=0100 at floor 0 -> MOVE next cycle; floor 1 after 4 cycles, floor 2 after 8; door_open 3 cycles; pending back to 0; IDLE.
- At floor 2 moving up with pending=1000, req=0001 -> serves 3 first, then reverses (dir_up=0) and serves 0 with no intermediate stops at 2 or 1.
- req for current floor during DOOR at door cycle 2 -> door_open lasts 2+3 cycles total; pending unchanged.
- Reset asserted mid-MOVE between floors 1 and 2 -> immediately floor_idx=0, moving=0, pending=0.
- With LIFT_DOOR_HOLD_EN: door_hold=1 for 5 cycles during DOOR -> door stays open, then closes exactly 3 cycles after release.
